// File: rtl/bit32_and.sv
// ---------------------------------------------------------------------------
// bit32_and
//   32-bit bitwise AND unit for the MultDiv/ALU datapath.
//   data_result is the purely combinational A & B for same-cycle consumers.
//   result_q/zero_q/ones_q are a one-stage registered copy of it, loaded when
//   in_valid is high. out_valid marks the cycle right after a capture.
//
// Optional build macro:
//   BIT32_AND_PARITY_EN  adds parity_q, the registered XOR-reduction of A & B.
//
// Ports:
//   clock          in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   data_operandA  in   [WIDTH-1:0] operand A
//   data_operandB  in   [WIDTH-1:0] operand B
//   in_valid       in   operands are valid this cycle
//   data_result    out  [WIDTH-1:0] combinational A & B
//   result_q       out  [WIDTH-1:0] registered A & B
//   out_valid      out  result_q and flags hold a fresh result
//   zero_q         out  registered result_q == 0
//   ones_q         out  registered result_q == all ones
//   parity_q       out  registered ^(A & B)   (BIT32_AND_PARITY_EN only)
// ---------------------------------------------------------------------------
module bit32_and #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             in_valid,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] result_q,
  output logic             out_valid,
  output logic             zero_q,
  output logic             ones_q
`ifdef BIT32_AND_PARITY_EN
  ,
  output logic             parity_q
`endif
);

  assign data_result = data_operandA & data_operandB;

  // Flags are computed from the same value that lands in result_q, so they
  // can never disagree with it; reset state (result 0) reports zero_q = 1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      ones_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result_q <= data_result;
        zero_q   <= (data_result == '0);
        ones_q   <= &data_result;
      end
    end
  end

`ifdef BIT32_AND_PARITY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else if (in_valid) begin
      parity_q <= ^data_result;
    end
  end
`endif

endmodule

// File: tb/tb_bit32_and.sv
// ---------------------------------------------------------------------------
// tb_bit32_and
//   Directed-vector bench for bit32_and. A reference model tracks the last
//   accepted operation and the cycle it was accepted in; a compare process
//   checks every DUT output against it on each falling edge. Directed
//   checks with hand-computed literals pin the model down.
// ---------------------------------------------------------------------------
module tb_bit32_and;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] a       = '0;
  logic [31:0] b       = '0;
  logic        in_valid = 1'b0;
  logic [31:0] data_result;
  logic [31:0] result_q;
  logic        out_valid;
  logic        zero_q;
  logic        ones_q;
`ifdef BIT32_AND_PARITY_EN
  logic        parity_q;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  bit32_and #(.WIDTH(32)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .data_operandA (a),
    .data_operandB (b),
    .in_valid      (in_valid),
    .data_result   (data_result),
    .result_q      (result_q),
    .out_valid     (out_valid),
    .zero_q        (zero_q),
    .ones_q        (ones_q)
`ifdef BIT32_AND_PARITY_EN
    ,
    .parity_q      (parity_q)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: the most recently accepted result and the cycle number
  // it was accepted in. A result is "fresh" only in the cycle that follows
  // its acceptance; reset forgets everything.
  int          cyc     = 0;
  int          acc_cyc = -10;
  logic [31:0] m_res   = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_res   = '0;
      acc_cyc = -10;
    end else begin
      cyc = cyc + 1;
      if (in_valid) begin
        m_res   = a & b;
        acc_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model on every falling edge.
  always @(negedge clock) begin
    if ($time > 2) begin
      chk("cmp_data_result", data_result, a & b);
      chk("cmp_result_q", result_q, m_res);
      chk("cmp_out_valid", {31'd0, out_valid}, {31'd0, acc_cyc == cyc});
      chk("cmp_zero_q", {31'd0, zero_q}, {31'd0, m_res == 32'd0});
      chk("cmp_ones_q", {31'd0, ones_q}, {31'd0, m_res == 32'hFFFF_FFFF});
`ifdef BIT32_AND_PARITY_EN
      chk("cmp_parity_q", {31'd0, parity_q}, {31'd0, ($countones(m_res) % 2) == 1});
`endif
    end
  end

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_result_q", result_q, 32'h0);
    chk("rst_zero_q", {31'd0, zero_q}, 32'd1);
    chk("rst_ones_q", {31'd0, ones_q}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    tick;
    tick;
    reset_n = 1'b1;
    tick;
    tick;
    chk("idle_result_q", result_q, 32'h0);
    chk("idle_zero_q", {31'd0, zero_q}, 32'd1);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Combinational sweep: A = 0, B = 0..30.
    for (int i = 0; i <= 30; i++) begin
      a = 32'h0;
      b = i;
      #20;
      chk("sweep_data_result", data_result, 32'h0);
    end
    tick;

    // Bitwise (not logical) AND, then one registered capture.
    a = 32'hFFFF_FFFF;
    b = 32'hA5A5_A5A5;
    in_valid = 1'b1;
    #1;
    chk("a5_data_result", data_result, 32'hA5A5_A5A5);
    tick;
    in_valid = 1'b0;
    chk("a5_result_q", result_q, 32'hA5A5_A5A5);
    chk("a5_zero_q", {31'd0, zero_q}, 32'd0);
    chk("a5_ones_q", {31'd0, ones_q}, 32'd0);
    chk("a5_out_valid", {31'd0, out_valid}, 32'd1);
    tick;
    chk("a5_hold_out_valid", {31'd0, out_valid}, 32'd0);
    chk("a5_hold_result_q", result_q, 32'hA5A5_A5A5);

    // Back-to-back accepted operations.
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    tick;
    chk("b2b1_result_q", result_q, 32'hFFFF_FFFF);
    chk("b2b1_ones_q", {31'd0, ones_q}, 32'd1);
    chk("b2b1_out_valid", {31'd0, out_valid}, 32'd1);
    a = 32'hF0F0_F0F0;
    b = 32'h0F0F_0F0F;
    tick;
    in_valid = 1'b0;
    chk("b2b2_result_q", result_q, 32'h0);
    chk("b2b2_zero_q", {31'd0, zero_q}, 32'd1);
    chk("b2b2_ones_q", {31'd0, ones_q}, 32'd0);
    chk("b2b2_out_valid", {31'd0, out_valid}, 32'd1);
    tick;

`ifdef BIT32_AND_PARITY_EN
    a = 32'h0000_0007;
    b = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    tick;
    chk("par_odd", {31'd0, parity_q}, 32'd1);
    a = 32'h0000_0003;
    tick;
    in_valid = 1'b0;
    chk("par_even", {31'd0, parity_q}, 32'd0);
    tick;
`endif

    // Reset asserted mid-operation, between clock edges.
    a = 32'h1234_5678;
    b = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("mid_pre_result_q", result_q, 32'h1234_5678);
    chk("mid_pre_out_valid", {31'd0, out_valid}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result_q", result_q, 32'h0);
    chk("mid_rst_zero_q", {31'd0, zero_q}, 32'd1);
    a = 32'h0F0F_00FF;
    b = 32'h00FF_0FF0;
    #1;
    chk("mid_rst_data_result", data_result, 32'h000F_00F0);
    tick;
    reset_n = 1'b1;
    tick;
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bit32_and.md
Name: bit32_and

Overview:
- 32-bit bitwise AND unit for the MultDiv/ALU datapath.
- Provides a combinational result for same-cycle consumers.
- Also provides a one-stage registered copy of the result with a valid strobe and status flags, for the multi-cycle multiply/divide control.
- Pure logic: no arithmetic, carries or state beyond the output register stage.

Parameters:
- WIDTH, 32, operand and result width in bits; only 32 is supported and verified.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- data_operandA  input  32  operand A.
- data_operandB  input  32  operand B.
- in_valid  input  1  operands valid this cycle; captured on rising clock.
- data_result  output  32  combinational A & B.
- result_q  output  32  registered A & B.
- out_valid  output  1  result_q and the flags hold a fresh result.
- zero_q  output  1  registered: result_q == 0.
- ones_q  output  1  registered: result_q == 32'hFFFFFFFF.

Behaviour:
- data_result[i] = data_operandA[i] & data_operandB[i] for every i in 0..31.
  - Bitwise, not logical, AND.
  - Purely combinational, zero cycles of latency, independent of clock, reset_n and in_valid.
  - Settles within one bench delay step.
- Asynchronous reset, while reset_n = 0:
  - result_q = 0, zero_q = 1, ones_q = 0, out_valid = 0.
  - Takes effect immediately, without a clock edge.
  - Deassertion is sampled on the next rising edge.
  - Reset asserted mid-operation discards any pending result; out_valid drops at once.
- Registered path, on a rising clock with reset_n = 1:
  - If in_valid = 1: result_q <= A & B; zero_q <= (A & B) == 0; ones_q <= (A & B) == all ones; out_valid <= 1.
  - If in_valid = 0: result_q, zero_q and ones_q hold their values; out_valid <= 0.
- Latency and throughput:
  - Registered latency is exactly 1 cycle.
  - Throughput is one operation per cycle; back-to-back in_valid is allowed.
  - No backpressure and no ready signal.
- Flags are always consistent with result_q. zero_q and ones_q are never both 1.
- X or Z inputs follow normal 4-state AND semantics; there is no special handling.

Optional Feature:
- Macro: BIT32_AND_PARITY_EN.
- When defined:
  - Adds output parity_q, 1 bit, the registered even-parity XOR-reduction of A & B.
  - It is updated under the same in_valid rule as result_q.
  - It resets to 0.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Apply reset_n = 0 with no clock edge -> result_q = 0, zero_q = 1, ones_q = 0, out_valid = 0 immediately. Release reset, hold in_valid = 0 for 2 clocks -> all registered outputs unchanged.
- Sweep A = 0, B = 0..30 with 20 ns spacing -> data_result = 0 every step. Check data_result against the bitwise AND golden, not the logical && golden.
- A = 32'hFFFFFFFF, B = 32'hA5A5A5A5 -> data_result = 32'hA5A5A5A5.
  - With in_valid = 1 for one clock: result_q = 32'hA5A5A5A5, zero_q = 0, ones_q = 0 and out_valid = 1 one cycle after the edge.
  - The next cycle, with in_valid = 0: out_valid = 0 and result_q is held.
- Back-to-back inputs with in_valid = 1 on consecutive edges:
  - (FFFFFFFF, FFFFFFFF) -> result_q = FFFFFFFF, ones_q = 1.
  - Then (F0F0F0F0, 0F0F0F0F) -> result_q = 0, zero_q = 1.
  - out_valid stays 1 across both.
- Assert reset_n = 0 between clock edges while out_valid = 1 with result_q = 12345678 -> out_valid = 0 and result_q = 0 asynchronously. data_result continues to track its inputs during reset.
- With BIT32_AND_PARITY_EN defined: A = 32'h00000007, B = 32'hFFFFFFFF, in_valid = 1 -> parity_q = 1. Then A = 32'h00000003 -> parity_q = 0.
